// File: rtl/mult16_pkg.sv
// Shared constants and FSM state encoding for the sequential shift-add multiplier.
package mult16_pkg;
  localparam int WIDTH = 16;
  localparam int CNT_W = 5;
  localparam int ITER  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/mult16_adder17.sv
// Per-iteration add: two W-bit operands to a (W+1)-bit sum that keeps the carry.
module adder17 #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W:0]   o_sum
);
  assign o_sum = {1'b0, i_a} + {1'b0, i_b};
endmodule

// File: rtl/mult16_seq.sv
// Sequential unsigned shift-add multiplier: 16 iterations, then a one-cycle load
// pulse with the registered product, aimed at a downstream load-enable register.
module mult16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_load,
  output logic [WIDTH-1:0] o_product_lo,
  output logic [WIDTH-1:0] o_product_hi,
  output logic             o_overflow
);
  import mult16_pkg::*;

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_prod_lo;
  logic [WIDTH-1:0] r_prod_hi;
  logic             r_ovf;
  logic             r_busy;
  logic             r_load;

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_mpl_nxt;
  logic             w_last;

  assign w_addend = r_mplier[0] ? r_mcand : '0;

  adder17 #(.W(WIDTH)) u_add (
    .i_a   (r_acc),
    .i_b   (w_addend),
    .o_sum (w_sum)
  );

  // The sum's low bit shifts into the multiplier's top; the carry lands in acc's MSB.
  assign w_acc_nxt = w_sum[WIDTH:1];
  assign w_mpl_nxt = {w_sum[0], r_mplier[WIDTH-1:1]};
  assign w_last    = (r_cnt == CNT_W'(ITER - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_prod_lo <= '0;
      r_prod_hi <= '0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
      r_load    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_load <= 1'b0;
          if (i_start) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_acc    <= w_acc_nxt;
          r_mplier <= w_mpl_nxt;
          r_cnt    <= r_cnt + 1'b1;
          // Products are registered on the last iteration so they are valid with load.
          if (w_last) begin
            r_prod_hi <= w_acc_nxt;
            r_prod_lo <= w_mpl_nxt;
            r_ovf     <= |w_acc_nxt;
            r_load    <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_load  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_load  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_load       = r_load;
  assign o_product_lo = r_prod_lo;
  assign o_product_hi = r_prod_hi;
  assign o_overflow   = r_ovf;
endmodule

// File: tb/tb_mult16_seq.sv
// Directed-vector bench for mult16_seq with a model of the downstream load-enable register.
module tb_mult16_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        busy, load, ovf;
  logic [15:0] plo, phi;
  logic [15:0] q;
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          load_cnt = 0;

  mult16_seq #(.WIDTH(16)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_a          (a),
    .i_b          (b),
    .o_busy       (busy),
    .o_load       (load),
    .o_product_lo (plo),
    .o_product_hi (phi),
    .o_overflow   (ovf)
  );

  always #5 clk = ~clk;

  // Downstream 16-bit register: D = product_lo, select = load.
  always @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else if (load) q <= plo;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load) load_cnt <= load_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one cycle; returns at E0+1.
  task automatic start_op(input logic [15:0] va, input logic [15:0] vb);
    a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // From E0+1, wait for load; k is the edge count after E0 at which load rose.
  task automatic wait_load(output int k);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (load) begin
        k = i;
        break;
      end
    end
    if (k < 0) chk("load_timeout", 32'd0, 32'd1);
  endtask

  int k, lc0, t1, t2, bcnt;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_load", load, 0);
    chk("rst_prod", {phi, plo}, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk); rst = 1'b0;
    tick();

    // Basic product 3*5
    lc0 = load_cnt;
    start_op(16'd3, 16'd5);
    chk("basic_busy", busy, 1);
    wait_load(k);
    chk("basic_capture_edge", k + 1, 17);
    chk("basic_prod", {phi, plo}, 32'h0000_000F);
    chk("basic_ovf", ovf, 0);
    tick();
    chk("basic_idle", {busy, load}, 0);
    chk("basic_q", q, 16'h000F);
    chk("basic_one_load", load_cnt - lc0, 1);

    // Maximum operands
    start_op(16'hFFFF, 16'hFFFF);
    wait_load(k);
    chk("max_prod", {phi, plo}, 32'hFFFE_0001);
    chk("max_ovf", ovf, 1);
    tick();
    chk("max_q", q, 16'h0001);

    // Zero multiplier then hold
    start_op(16'h1234, 16'h0000);
    wait_load(k);
    chk("zero_prod", {phi, plo}, 0);
    chk("zero_ovf", ovf, 0);
    tick();
    lc0 = load_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("zero_hold", {phi, plo, ovf}, 0);
    end
    chk("zero_no_load", load_cnt - lc0, 0);

    // start while busy: at E5 and in the DONE cycle
    lc0 = load_cnt;
    start_op(16'd7, 16'd9);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 4) begin a = 16'hFFFF; b = 16'hFFFF; start = 1'b1; end
      if (i == 5) start = 1'b0;
      if (load) begin k = i; break; end
    end
    if (k < 0) chk("busy_start_timeout", 32'd0, 32'd1);
    chk("busy_start_edge", k + 1, 17);
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_fall", {busy, load}, 0);
    chk("busy_start_prod", {phi, plo}, 32'h0000_003F);
    bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy) bcnt++;
    end
    chk("busy_start_no_second", bcnt, 0);
    chk("busy_start_one_load", load_cnt - lc0, 1);

    // Reset mid-operation at E8
    start_op(16'h00FF, 16'h0101);
    for (int i = 1; i <= 7; i++) tick();
    chk("mid_busy_pre", busy, 1);
    chk("mid_hold_pre", plo, 16'h003F);
    rst = 1'b1;
    #1;
    chk("mid_rst_async", {busy, load}, 0);
    chk("mid_rst_prod", {phi, plo, ovf}, 0);
    tick();
    rst = 1'b0;
    lc0 = load_cnt;
    for (int i = 0; i < 20; i++) tick();
    chk("mid_no_load", load_cnt - lc0, 0);
    start_op(16'd2, 16'd3);
    wait_load(k);
    chk("mid_fresh_lo", plo, 16'd6);
    tick();

    // Back-to-back
    start_op(16'h00FF, 16'h0101);
    wait_load(k);
    t1 = cyc;
    chk("b2b_first", {phi, plo}, 32'h0000_FFFF);
    tick();
    start_op(16'h0100, 16'h0100);
    wait_load(k);
    t2 = cyc;
    chk("b2b_spacing", t2 - t1, 18);
    chk("b2b_prod", {phi, plo}, 32'h0001_0000);
    chk("b2b_ovf", ovf, 1);
    tick();
    chk("b2b_q", q, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mult16_seq.md
# mult16_seq

Sequential unsigned shift-add multiplier. It takes two 16-bit operands on a `start` pulse and returns a 32-bit product after a fixed latency. It sits directly upstream of the datapath's 16-bit load-enable registers:
- `product_lo` drives a register's `D` input.
- `load` drives its `select` input for exactly one cycle, so the result is captured on the same edge the product becomes valid.

## Interface
- `WIDTH`, default 16, operand and half-product width. Only 16 is verified.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  multiplicand; sampled with `start`.
- `b`  in  WIDTH  multiplier; sampled with `start`.
- `busy`  out  1  high in RUN and DONE.
- `load`  out  1  one-cycle pulse; products valid; wired to the downstream register `select`.
- `product_lo`  out  WIDTH  low half of `a*b`.
- `product_hi`  out  WIDTH  high half of `a*b`.
- `overflow`  out  1  `product_hi != 0`; meaningful from the `load` cycle onward.

## Operation
- **State machine:** IDLE, RUN, DONE.
- **IDLE:**
  - `start`=1 latches `a` into `mcand` and `b` into `mplier`.
  - Clears the accumulator `acc` and the 5-bit iteration counter.
  - Goes to RUN.
  - `start`=0 stays in IDLE.
- **RUN, one iteration per clock:**
  - `sum = {1'b0,acc} + (mplier[0] ? mcand : 0)`, 17 bits.
  - `{acc, mplier} <= {sum, mplier} >> 1`; the carry enters `acc[15]`.
  - The counter increments.
  - After the 16th iteration, go to DONE.
- **DONE:**
  - `product_hi <= acc`, `product_lo <= mplier` are registered on entry.
  - `load`=1 for this single cycle.
  - The next state is always IDLE.
- **Output hold:** `product_hi`, `product_lo` and `overflow` hold their values until the next DONE entry or reset.
- **`start` outside IDLE:** ignored, including in DONE. It is not queued.
- **Arithmetic:** unsigned only. The full 32-bit product is exact. The 16-bit downstream register receives `product_lo` only, and `overflow` flags the truncation.
- **Reset:** `rst`=1 at any time, including mid-RUN:
  - Forces IDLE.
  - Clears `acc`, `mcand`, `mplier`, the counter, `product_lo`, `product_hi`, `overflow`, `busy` and `load` to 0.
  - An aborted operation never produces `load`.

## Timing
- **Reset values:** `busy`=0, `load`=0, `product_lo`=0, `product_hi`=0, `overflow`=0.
- **Cycle count:**
  - Edge E0 samples `start`=1 in IDLE. `busy` rises after E0.
  - Edges E1–E16 perform the 16 iterations. State is DONE after E16.
  - Products update and `load`=1 during the cycle after E16.
  - The downstream register captures on E17. State is IDLE after E17, with `busy`=0 and `load`=0.
- **Latency:** 17 cycles from the `start` sample edge to the capture edge.
- **Throughput:** the earliest next `start` sample is E17's cycle, i.e. the edge after IDLE re-entry is E18. One operation per 18 cycles.
- **Output registration:** `load`, `busy` and the products are registered or decoded from registered state only. There are no combinational paths from `start`, `a` or `b` to any output.
- **Operand stability:** `a` and `b` need only be stable at E0.

## Structure
- **Shared package `mult16_pkg`:**
  - `WIDTH` = 16.
  - `CNT_W` = 5.
  - `ITER` = 16.
  - State typedef: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10.
- **Sub-module `adder17`:** the per-iteration add, 16+16 bits to a 17-bit sum with carry. It is kept separate so the datapath's existing adder style can be reused.
- **Top level:** the FSM, counter and shift registers live in `mult16_seq`.

## Test plan
- **Basic product:**
  - Stimulus: `a`=3, `b`=5, `start` for 1 cycle.
  - Required response:
    - `load` high in exactly one cycle, 17 edges after E0.
    - `product_lo`=0x000F, `product_hi`=0x0000, `overflow`=0.
    - Downstream register Q=0x000F after the capture edge.
- **Maximum operands:**
  - Stimulus: `a`=0xFFFF, `b`=0xFFFF.
  - Required response: `product_hi`=0xFFFE, `product_lo`=0x0001, `overflow`=1.
- **Zero multiplier, then hold:**
  - Stimulus: `a`=0x1234, `b`=0, `start` for 1 cycle. Then idle 5 cycles.
  - Required response: `product_lo`=`product_hi`=0, `overflow`=0. Products stay 0 and `load` stays 0 through the idle cycles.
- **`start` while busy:**
  - Stimulus: `a`=7, `b`=9 with `start`. At E5 and again in the DONE cycle, assert `start` with `a`=`b`=0xFFFF.
  - Required response: result is 0x003F. Exactly one `load`, `busy` falls after E17, and no second operation starts.
- **Reset mid-operation:**
  - Stimulus: `a`=0x00FF, `b`=0x0101. Assert `rst` for 1 cycle at E8, then release.
  - Required response: `busy` and `load` drop asynchronously and all outputs read 0. No `load` for 20 cycles afterwards. A fresh `start` with 2×3 gives `product_lo`=6.
- **Back-to-back:**
  - Stimulus: a second `start` with 0x0100×0x0100 on the first eligible edge after IDLE re-entry.
  - Required response: the two `load` pulses are 18 cycles apart. Second result has `product_hi`=0x0001, `product_lo`=0x0000, `overflow`=1.
